sweep_sequencer: RTL and testbench

//  Run-time controller for the imit_signal test-signal generator. Steps it through a fixed table of stimulus profiles
//  (carrier frequency, sweep step, AM rate, AM depth). For each profile: load the config, hold the generator in reset,

---
 rtl/sweep_pkg.sv | 39 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/sweep_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_sweep_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types for the sweep sequencer: the stimulus profile record, the fixed
// profile table and the sequencer FSM state encoding.
package sweep_pkg;

  typedef struct packed {
    logic [31:0] start_freq;
    logic [31:0] step;
    logic [31:0] am_step;
    logic [15:0] am_depth;
    logic        am_en;
  } profile_t;

  localparam profile_t PROFILES [4] = '{
    '{start_freq: 32'h0000_0500, step: 32'h0000_0000, am_step: 32'h0000_0000,
      am_depth: 16'd0,     am_en: 1'b0},
    '{start_freq: 32'h0000_0500, step: 32'h0000_0010, am_step: 32'h0000_0000,
      am_depth: 16'd0,     am_en: 1'b0},
    '{start_freq: 32'h0000_0500, step: 32'h0000_0000, am_step: 32'h0400_0000,
      am_depth: 16'd26214, am_en: 1'b1},
    '{start_freq: 32'h0000_0200, step: 32'h0000_0008, am_step: 32'h0100_0000,
      am_depth: 16'd16384, am_en: 1'b1}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_FIRE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == S_LOAD) || (s == S_SETTLE) || (s == S_FIRE) ||
           (s == S_RUN)  || (s == S_GAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Start-button conditioner: 2-flop synchroniser, stable-level debounce counter
// and a one-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the
  // debounced level; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_rise = rise_q;

endmodule

// File: rtl/sweep_sequencer.sv
// Run-time controller for the imit_signal generator: walks the profile table,
// loading config, holding reset, firing start and counting samples per profile.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int NUM_PROFILES     = 4,
  parameter int SAMPLES_PER_PROF = 1024,
  parameter int SETTLE_CYCLES    = 8,
  parameter int GAP_CYCLES       = 16,
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int LOOP             = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_btn_start,
  input  logic        i_abort,
  input  logic        i_gen_valid,
  output logic        o_gen_rst,
  output logic        o_gen_start,
  output logic [31:0] o_start_freq,
  output logic [31:0] o_step,
  output logic [31:0] o_am_step,
  output logic [15:0] o_am_depth,
  output logic        o_am_en,
  output logic [1:0]  o_profile,
  output logic [15:0] o_sample_cnt,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CNT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0]      SPP_LAST    = 16'(SAMPLES_PER_PROF - 1);
  localparam logic [1:0]       PROF_LAST   = 2'(NUM_PROFILES - 1);

  if (SAMPLES_PER_PROF < 1 || SAMPLES_PER_PROF > 65535) begin : g_bad_spp
    $error("SAMPLES_PER_PROF must be in 1..65535");
  end
  if (NUM_PROFILES < 1 || NUM_PROFILES > 4) begin : g_bad_np
    $error("NUM_PROFILES must be in 1..4");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end

  logic start_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (i_btn_start),
    .o_rise (start_evt)
  );

  state_t           state_q, state_d;
  logic [1:0]       profile_q, profile_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;
  profile_t         cfg_q, cfg_d;
  logic             gen_rst_q, gen_rst_d;
  logic             gen_start_q, gen_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Where the sequence goes once a profile (and its gap) is finished.
  state_t     adv_state;
  logic [1:0] adv_profile;

  always_comb begin
    adv_state   = S_LOAD;
    adv_profile = profile_q + 2'd1;
    if (profile_q >= PROF_LAST) begin
      adv_profile = (LOOP != 0) ? 2'd0 : profile_q;
      adv_state   = (LOOP != 0) ? S_LOAD : S_DONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    profile_d    = profile_q;
    cnt_d        = cnt_q;
    sample_cnt_d = sample_cnt_q;
    cfg_d        = cfg_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_evt) begin
          state_d   = S_LOAD;
          profile_d = 2'd0;
        end
      end
      S_LOAD: begin
        cfg_d   = PROFILES[profile_q];
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_FIRE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      S_FIRE: begin
        sample_cnt_d = '0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        if (i_gen_valid) begin
          if (sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
          if (sample_cnt_q == SPP_LAST) begin
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              cnt_d   = '0;
            end else begin
              state_d   = adv_state;
              profile_d = adv_profile;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d   = adv_state;
          profile_d = adv_profile;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything else; progress and config are frozen.
    if (i_abort && is_busy(state_q)) begin
      state_d      = S_IDLE;
      profile_d    = profile_q;
      sample_cnt_d = sample_cnt_q;
      cfg_d        = cfg_q;
    end

    gen_rst_d   = !((state_d == S_FIRE) || (state_d == S_RUN));
    gen_start_d = (state_d == S_FIRE);
    busy_d      = is_busy(state_d);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      profile_q    <= '0;
      cnt_q        <= '0;
      sample_cnt_q <= '0;
      cfg_q        <= '0;
      gen_rst_q    <= 1'b1;
      gen_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      profile_q    <= profile_d;
      cnt_q        <= cnt_d;
      sample_cnt_q <= sample_cnt_d;
      cfg_q        <= cfg_d;
      gen_rst_q    <= gen_rst_d;
      gen_start_q  <= gen_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_gen_rst    = gen_rst_q;
  assign o_gen_start  = gen_start_q;
  assign o_start_freq = cfg_q.start_freq;
  assign o_step       = cfg_q.step;
  assign o_am_step    = cfg_q.am_step;
  assign o_am_depth   = cfg_q.am_depth;
  assign o_am_en      = cfg_q.am_en;
  assign o_profile    = profile_q;
  assign o_sample_cnt = sample_cnt_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: one LOOP=0 and one LOOP=1 instance share
// all inputs; valid strobes every 4th cycle.
module tb_sweep_sequencer;

  logic clk = 1'b0;
  logic rst_n, btn, abort, vld;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        d0_gen_rst, d0_gen_start, d0_am_en, d0_busy, d0_done;
  logic [31:0] d0_start_freq, d0_step, d0_am_step;
  logic [15:0] d0_am_depth, d0_sample_cnt;
  logic [1:0]  d0_profile;
  logic        d1_gen_rst, d1_gen_start, d1_am_en, d1_busy, d1_done;
  logic [31:0] d1_start_freq, d1_step, d1_am_step;
  logic [15:0] d1_am_depth, d1_sample_cnt;
  logic [1:0]  d1_profile;

  sweep_sequencer #(.NUM_PROFILES(4), .SAMPLES_PER_PROF(8), .SETTLE_CYCLES(2),
                    .GAP_CYCLES(3), .DEBOUNCE_CYCLES(4), .LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_btn_start(btn), .i_abort(abort), .i_gen_valid(vld),
    .o_gen_rst(d0_gen_rst), .o_gen_start(d0_gen_start), .o_start_freq(d0_start_freq),
    .o_step(d0_step), .o_am_step(d0_am_step), .o_am_depth(d0_am_depth), .o_am_en(d0_am_en),
    .o_profile(d0_profile), .o_sample_cnt(d0_sample_cnt), .o_busy(d0_busy), .o_done(d0_done));

  sweep_sequencer #(.NUM_PROFILES(4), .SAMPLES_PER_PROF(8), .SETTLE_CYCLES(2),
                    .GAP_CYCLES(3), .DEBOUNCE_CYCLES(4), .LOOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_btn_start(btn), .i_abort(abort), .i_gen_valid(vld),
    .o_gen_rst(d1_gen_rst), .o_gen_start(d1_gen_start), .o_start_freq(d1_start_freq),
    .o_step(d1_step), .o_am_step(d1_am_step), .o_am_depth(d1_am_depth), .o_am_en(d1_am_en),
    .o_profile(d1_profile), .o_sample_cnt(d1_sample_cnt), .o_busy(d1_busy), .o_done(d1_done));

  // Passive record of start pulses, reset-run lengths and config stability.
  int           starts0 = 0, run0 = 0, last_gap0 = 0, cfg_bad0 = 0;
  bit           done1_seen = 1'b0;
  logic [1:0]   prof_seen [8];
  logic [31:0]  freq_seen [8];
  logic [15:0]  dep_seen  [8];
  logic         en_seen   [8];
  logic [112:0] prev_cfg0 = '0;

  always @(negedge clk) begin
    if (rst_n && d0_gen_start) begin
      if (starts0 < 8) begin
        prof_seen[starts0] = d0_profile;
        freq_seen[starts0] = d0_start_freq;
        dep_seen[starts0]  = d0_am_depth;
        en_seen[starts0]   = d0_am_en;
      end
      starts0++;
    end
    if (d0_gen_rst) run0++;
    else begin
      if (run0 > 0) last_gap0 = run0;
      run0 = 0;
    end
    if (!d0_gen_rst && prev_cfg0 != {d0_start_freq, d0_step, d0_am_step, d0_am_depth, d0_am_en})
      cfg_bad0++;
    prev_cfg0 = {d0_start_freq, d0_step, d0_am_step, d0_am_depth, d0_am_en};
    if (d1_done) done1_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    vld = (cyc % 4 == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds the button until dut0 fires a start (bounded); n = cycles taken.
  task automatic press_wait(output int n);
    n = 0;
    btn = 1'b1;
    do begin
      tick();
      n++;
    end while (!d0_gen_start && n < 40);
    btn = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0; btn = 1'b0; abort = 1'b0; vld = 1'b0;
    repeat (3) tick();
    chk("rst_flags", {27'd0, d0_gen_rst, d0_gen_start, d0_busy, d0_done, d0_am_en}, 32'b10000);
    chk("rst_freq", d0_start_freq, 32'h0);
    chk("rst_depth", {16'd0, d0_am_depth}, 32'h0);
    chk("rst_prof_cnt", {14'd0, d0_profile, d0_sample_cnt}, 32'h0);

    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_busy", {31'd0, d0_busy}, 32'd0);
    chk("idle_gen_rst", {31'd0, d0_gen_rst}, 32'd1);
    chk("idle_starts", starts0, 32'd0);

    // Glitch shorter than the debounce window
    btn = 1'b1;
    repeat (2) tick();
    btn = 1'b0;
    repeat (20) tick();
    chk("glitch_starts", starts0, 32'd0);
    chk("glitch_busy", {31'd0, d0_busy}, 32'd0);

    // 2 sync + 4 stable cycles to the start event, then 4 more to the pulse
    press_wait(n);
    chk("start_latency", n, 32'd10);
    chk("p0_profile", {30'd0, d0_profile}, 32'd0);
    chk("p0_freq", d0_start_freq, 32'h500);
    chk("p0_am_en", {31'd0, d0_am_en}, 32'd0);
    chk("p0_gen_rst", {31'd0, d0_gen_rst}, 32'd0);

    n = 0;
    while (!d0_done && n < 1000) begin tick(); n++; end
    chk("full_done", {31'd0, d0_done}, 32'd1);
    chk("full_starts", starts0, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("full_prof%0d", i), {30'd0, prof_seen[i]}, i);
    chk("p1_am_en", {31'd0, en_seen[1]}, 32'd0);
    chk("p2_depth", {16'd0, dep_seen[2]}, 32'd26214);
    chk("p2_am_en", {31'd0, en_seen[2]}, 32'd1);
    chk("p3_freq", freq_seen[3], 32'h200);
    chk("gap_len", last_gap0, 32'd6);
    chk("cfg_stable", cfg_bad0, 32'd0);
    chk("done_busy", {31'd0, d0_busy}, 32'd0);
    chk("done_gen_rst", {31'd0, d0_gen_rst}, 32'd1);
    chk("done_samples", {16'd0, d0_sample_cnt}, 32'd8);

    // LOOP=1 instance wraps to profile 0 on the same edge
    chk("loop_done", {31'd0, d1_done}, 32'd0);
    chk("loop_busy", {31'd0, d1_busy}, 32'd1);
    chk("loop_profile", {30'd0, d1_profile}, 32'd0);
    n = 0;
    while (!d1_gen_start && n < 20) begin tick(); n++; end
    chk("loop_restart", {31'd0, d1_gen_start}, 32'd1);
    chk("loop_freq", d1_start_freq, 32'h500);

    // Restart from DONE, then abort at sample 5 of profile 1
    press_wait(n);
    chk("restart_latency", n, 32'd10);
    chk("restart_profile", {30'd0, d0_profile}, 32'd0);
    n = 0;
    while (!(d0_profile == 2'd1 && d0_sample_cnt == 16'd5) && n < 500) begin tick(); n++; end
    chk("abort_reach", {14'd0, d0_profile, d0_sample_cnt}, {14'd0, 2'd1, 16'd5});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, d0_busy}, 32'd0);
    chk("abort_gen_rst", {31'd0, d0_gen_rst}, 32'd1);
    chk("abort_done", {31'd0, d0_done}, 32'd0);
    chk("abort_cfg_held", d0_step, 32'h10);
    repeat (10) tick();
    chk("abort_stays_idle", {31'd0, d0_busy}, 32'd0);

    press_wait(n);
    chk("after_abort_latency", n, 32'd10);
    chk("after_abort_profile", {30'd0, d0_profile}, 32'd0);
    chk("after_abort_step", d0_step, 32'h0);

    // Abort coincident with the 8th valid
    n = 0;
    while (!(d0_sample_cnt == 16'd7 && vld) && n < 200) begin tick(); n++; end
    chk("sim_reach", {16'd0, d0_sample_cnt}, 32'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("sim_busy", {31'd0, d0_busy}, 32'd0);
    chk("sim_gen_rst", {31'd0, d0_gen_rst}, 32'd1);
    chk("sim_samples", {16'd0, d0_sample_cnt}, 32'd7);

    // Button press inside RUN is ignored
    press_wait(n);
    chk("run_start_latency", n, 32'd10);
    repeat (6) tick();
    base = starts0;
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (8) tick();
    chk("run_btn_starts", starts0, base);
    chk("run_btn_profile", {30'd0, d0_profile}, 32'd0);
    chk("run_btn_busy", {31'd0, d0_busy}, 32'd1);

    // Asynchronous reset mid-RUN on the LOOP instance
    chk("pre_rst_run", {31'd0, d1_gen_rst}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {28'd0, d1_gen_rst, d1_gen_start, d1_busy, d1_am_en}, 32'b1000);
    chk("mid_rst_freq", d1_start_freq, 32'h0);
    chk("mid_rst_cnt", {14'd0, d1_profile, d1_sample_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", {31'd0, d1_busy}, 32'd0);
    chk("loop_never_done", {31'd0, done1_seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
